// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle NUM_WORDS x 32-bit add/subtract. It drives one shared
// external 32-bit combinational adder. The adder receives one slice per cycle,
// least significant word first, and the carry is chained between cycles.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request, accepted in IDLE or DONE
//   op_sub            0: A+B+cin, 1: A-B (cin ignored)
//   cin               carry-in for add mode
//   op_a, op_b        W-bit operands, sampled on accept
//   busy              high while slices are being fed to the adder
//   done              one-cycle completion pulse
//   sum, cout, ovf    wide result, carry out, signed overflow; held until next completion
//   add_a, add_b      slice operands to the external adder (0 outside RUN)
//   add_cin           carry into the external adder (0 outside RUN)
//   add_sum, add_cout combinational return from the external adder
module wide_add_seq #(
  parameter  int unsigned NUM_WORDS = 4,
  localparam int unsigned W         = 32 * NUM_WORDS,
  localparam int unsigned IW        = $clog2(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_sub,
  input  logic          cin,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  sum,
  output logic          cout,
  output logic          ovf,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_cin,
  input  logic [31:0]   add_sum,
  input  logic          add_cout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-33:0]   r_sh;    // words already produced; the current add_sum completes the result
  logic            carry;
  logic [IW-1:0]   idx;
  logic            a_msb;
  logic            b_msb;
  logic [W-1:0]    b_eff;
  logic [W-1:0]    res_next;

  // Effective B operand and the result as it stands after the current slice
  always_comb begin
    b_eff    = op_sub ? ~op_b : op_b;
    res_next = {add_sum, r_sh};
  end

  // The shift registers drain to zero after the last slice, and the carry is
  // cleared on completion, so the adder-side outputs are 0 outside RUN
  // without any extra gating.
  assign add_a   = a_sh[31:0];
  assign add_b   = b_sh[31:0];
  assign add_cin = carry;

  // Controller state, slice sequencing and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= b_eff;
            carry <= op_sub ? 1'b1 : cin;
            idx   <= '0;
            a_msb <= op_a[W-1];
            b_msb <= b_eff[W-1];
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh  <= {32'b0, a_sh[W-1:32]};
          b_sh  <= {32'b0, b_sh[W-1:32]};
          r_sh  <= res_next[W-1:32];
          carry <= add_cout;
          idx   <= idx + IW'(1);
          if (idx == IW'(NUM_WORDS - 1)) begin
            sum   <= res_next;
            cout  <= add_cout;
            // Overflow only when both operand signs agree and the result sign differs
            ovf   <= (a_msb == b_msb) && (add_sum[31] != a_msb);
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized and directed checks of wide_add_seq against a
// wide-arithmetic reference model, with a behavioural 32-bit adder attached.
module tb_wide_add_seq;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = 32 * NW;
  localparam int unsigned CW = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op_sub;
  logic          cin;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;

  int            passed = 0;
  int            total  = 0;
  int            busy_n;
  logic          cin_seq [16];
  logic [W-1:0]  last_sum;

  wide_add_seq #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Shared external 32-bit adder
  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact signed/unsigned wide arithmetic
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic c, output logic [W-1:0] s, output logic co, output logic ov);
    logic signed [W+1:0] sa, sb, t;
    logic [W:0]          u;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    if (sub) begin
      t  = sa - sb;
      co = (a >= b);
    end else begin
      t  = sa + sb + (W+2)'(c);
      u  = CW'(a) + CW'(b) + CW'(c);
      co = u[W];
    end
    s  = t[W-1:0];
    ov = !((t[W+1:W-1] == 3'b000) || (t[W+1:W-1] == 3'b111));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"},    CW'(busy),    '0);
    chk({tag, ".done"},    CW'(done),    '0);
    chk({tag, ".sum"},     CW'(sum),     '0);
    chk({tag, ".cout"},    CW'(cout),    '0);
    chk({tag, ".ovf"},     CW'(ovf),     '0);
    chk({tag, ".add_a"},   CW'(add_a),   '0);
    chk({tag, ".add_b"},   CW'(add_b),   '0);
    chk({tag, ".add_cin"}, CW'(add_cin), '0);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic c);
    op_a = a; op_b = b; op_sub = sub; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles until done appears (bounded), logging add_cin per RUN cycle
  task automatic wait_done();
    busy_n = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy) begin
        if (busy_n < 16) cin_seq[busy_n] = add_cin;
        busy_n++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic c, input int exp_busy);
    logic [W-1:0] es;
    logic         eco, eov;
    model(a, b, sub, c, es, eco, eov);
    chk({tag, ".done"},  CW'(done),   CW'(1));
    chk({tag, ".busy"},  CW'(busy),   '0);
    chk({tag, ".nbusy"}, CW'(busy_n), CW'(exp_busy));
    chk({tag, ".sum"},   CW'(sum),    CW'(es));
    chk({tag, ".cout"},  CW'(cout),   CW'(eco));
    chk({tag, ".ovf"},   CW'(ovf),    CW'(eov));
    chk({tag, ".add_a"}, CW'(add_a),  '0);
    last_sum = es;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic c);
    launch(a, b, sub, c);
    chk({tag, ".hold"}, CW'(sum), CW'(last_sum));
    wait_done();
    check_res(tag, a, b, sub, c, NW);
    @(posedge clk); #1;
    chk({tag, ".done_off"}, CW'(done), '0);
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ones, msb, a1, b1;
    logic [3:0]   seq;
    ones = '1;
    msb  = {1'b1, (W-1)'(0)};
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    last_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_op("allones_plus1", ones, W'(1), 1'b0, 1'b0);
    run_op("carry_chain", {32'h0, {96{1'b1}}}, W'(1), 1'b0, 1'b0);
    seq = {cin_seq[3], cin_seq[2], cin_seq[1], cin_seq[0]};
    chk("carry_chain.cin_seq", CW'(seq), CW'(4'b1110));
    run_op("sub_0_1", '0, W'(1), 1'b1, 1'b0);
    run_op("sub_5_3", W'(5), W'(3), 1'b1, 1'b1);
    run_op("ovf_pos", ~msb, W'(1), 1'b0, 1'b0);
    run_op("ovf_neg", msb, msb, 1'b0, 1'b0);
    run_op("sub_minneg", '0, msb, 1'b1, 1'b0);
    run_op("add_cin", ~msb, '0, 1'b0, 1'b1);

    // start during RUN is ignored; start in DONE is accepted back-to-back
    a1 = rnd_w(); b1 = rnd_w();
    launch(a1, b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    op_a = rnd_w(); op_b = rnd_w(); op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check_res("ignore_start", a1, b1, 1'b0, 1'b1, 2);
    launch(W'(2), W'(3), 1'b0, 1'b0);
    chk("b2b.done_off", CW'(done), '0);
    chk("b2b.busy_on",  CW'(busy), CW'(1));
    chk("b2b.hold",     CW'(sum),  CW'(last_sum));
    wait_done();
    check_res("b2b", W'(2), W'(3), 1'b0, 1'b0, NW);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN
    launch(rnd_w(), rnd_w(), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("midrun_rst");
    #2 rst = 1'b0;
    last_sum = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midrun_rst.no_done", CW'(done | busy), '0);
    end
    run_op("after_rst", W'(7), W'(9), 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra, rb;
      ra = rnd_w(); rb = rnd_w();
      if (n % 5 == 0) ra[W-1] = rb[W-1];
      run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
